// File: rtl/fbindct_pkg.sv
// fbindct_pkg: widths, types and lifting constants shared by the binDCT datapath.
package fbindct_pkg;

    localparam int IN_W  = 8;
    localparam int OUT_W = 32;

    typedef logic signed [IN_W-1:0]  sample_t;
    typedef logic signed [OUT_W-1:0] coef_t;

    // Lifting steps as numerator/shift pairs: y = a +/- ((K*b) >>> S)
    localparam int unsigned K_B0 = 13, S_B0 = 5;
    localparam int unsigned K_B1 = 11, S_B1 = 4;
    localparam int unsigned K_D2 = 3,  S_D2 = 3;
    localparam int unsigned K_D3 = 3,  S_D3 = 3;
    localparam int unsigned K_D4 = 1,  S_D4 = 3;
    localparam int unsigned K_D5 = 5,  S_D5 = 4;
    localparam int unsigned K_D6 = 9,  S_D6 = 4;
    localparam int unsigned K_X1 = 3,  S_X1 = 4;
    localparam int unsigned K_D1 = 1,  S_D1 = 1;

endpackage

// File: rtl/bindct_lift.sv
// bindct_lift: one multiplierless lifting step, y = a +/- ((K*b) >>> S).
module bindct_lift
    import fbindct_pkg::*;
#(
    parameter int unsigned K   = 1,
    parameter int unsigned S   = 0,
    parameter bit          SUB = 1'b0
) (
    input  coef_t a_i,
    input  coef_t b_i,
    output coef_t y_o
);

    coef_t prod;
    coef_t term;

    // Constant product built from one shifted copy of b per set bit of K
    always_comb begin
        prod = '0;
        for (int i = 0; i < 8; i++)
            if (K[i]) prod = prod + (b_i <<< i);
    end

    assign term = prod >>> S;
    assign y_o  = SUB ? a_i - term : a_i + term;

endmodule

// File: rtl/fbin_dct.sv
// fbin_dct: combinational 8-point forward binDCT (lifting-based integer DCT-II).
// clk and srstn exist only for interface uniformity and never reach the datapath.
module fbin_dct
    import fbindct_pkg::*;
(
    input  logic    clk,
    input  logic    srstn,
    input  sample_t x_in  [0:7],
    output coef_t   x_out [0:7]
);

    logic  unused_ok;
    coef_t xe [0:7];
    coef_t a0, a1, a2, a3, a4, a5, a6, a7;
    coef_t b0, b1;
    coef_t c0, c1, c2, c3, c4, c5, c6, c7;
    coef_t d0, d1, d2, d3, d4, d5, d6;
    coef_t x1;

    assign unused_ok = clk ^ srstn;

    always_comb begin
        for (int i = 0; i < 8; i++)
            xe[i] = coef_t'(x_in[i]);
    end

    assign a0 = xe[0] + xe[7];
    assign a1 = xe[1] + xe[6];
    assign a2 = xe[2] + xe[5];
    assign a3 = xe[3] + xe[4];
    assign a4 = xe[3] - xe[4];
    assign a5 = xe[2] - xe[5];
    assign a6 = xe[1] - xe[6];
    assign a7 = xe[0] - xe[7];

    bindct_lift #(.K(K_B0), .S(S_B0), .SUB(1'b1)) u_b0 (.a_i(a6), .b_i(a5), .y_o(b0));
    bindct_lift #(.K(K_B1), .S(S_B1), .SUB(1'b0)) u_b1 (.a_i(a5), .b_i(b0), .y_o(b1));

    assign c0 = a0 + a3;
    assign c1 = a1 + a2;
    assign c2 = a1 - a2;
    assign c3 = a0 - a3;
    assign c4 = a4 + b1;
    assign c5 = a4 - b1;
    assign c6 = a7 - b0;
    assign c7 = a7 + b0;

    assign d0 = c0 + c1;

    // d1 = (d0 >>> 1) - c1, expressed as a lifting step on -c1
    bindct_lift #(.K(K_D1), .S(S_D1), .SUB(1'b0)) u_d1 (.a_i(-c1), .b_i(d0), .y_o(d1));
    bindct_lift #(.K(K_D2), .S(S_D2), .SUB(1'b1)) u_d2 (.a_i(c2),  .b_i(c3), .y_o(d2));
    bindct_lift #(.K(K_D3), .S(S_D3), .SUB(1'b0)) u_d3 (.a_i(c3),  .b_i(d2), .y_o(d3));
    bindct_lift #(.K(K_D4), .S(S_D4), .SUB(1'b0)) u_d4 (.a_i(c4),  .b_i(c7), .y_o(d4));
    bindct_lift #(.K(K_D5), .S(S_D5), .SUB(1'b0)) u_d5 (.a_i(c5),  .b_i(c6), .y_o(d5));
    bindct_lift #(.K(K_D6), .S(S_D6), .SUB(1'b1)) u_d6 (.a_i(c6),  .b_i(d5), .y_o(d6));
    bindct_lift #(.K(K_X1), .S(S_X1), .SUB(1'b1)) u_x1 (.a_i(c7),  .b_i(d4), .y_o(x1));

    assign x_out[0] = d0;
    assign x_out[1] = x1;
    assign x_out[2] = d3;
    assign x_out[3] = d6;
    assign x_out[4] = d1;
    assign x_out[5] = d5;
    assign x_out[6] = d2;
    assign x_out[7] = d4;

endmodule

// File: tb/tb_fbin_dct.sv
// tb_fbin_dct: directed vectors with hand-computed coefficients for fbin_dct.
module tb_fbin_dct;
    import fbindct_pkg::*;

    logic    clk = 1'b0;
    logic    srstn = 1'b0;
    sample_t x_in  [0:7];
    coef_t   x_out [0:7];
    coef_t   ex    [0:7];
    int      n_assert = 0;
    int      n_fail = 0;

    fbin_dct dut (.clk(clk), .srstn(srstn), .x_in(x_in), .x_out(x_out));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input coef_t obs, input coef_t expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic chk_out(input string tag);
        for (int i = 0; i < 8; i++)
            chk($sformatf("%s X%0d", tag, i), x_out[i], ex[i]);
    endtask

    initial begin
        x_in = '{64, 32, 24, 28, 40, 34, 26, 12};
        #1;
        chk("v1 a0", dut.a0, 76);  chk("v1 a1", dut.a1, 58);
        chk("v1 a2", dut.a2, 58);  chk("v1 a3", dut.a3, 68);
        chk("v1 a4", dut.a4, -12); chk("v1 a5", dut.a5, -10);
        chk("v1 a6", dut.a6, 6);   chk("v1 a7", dut.a7, 52);
        chk("v1 b0", dut.b0, 11);  chk("v1 b1", dut.b1, -3);
        chk("v1 c0", dut.c0, 144); chk("v1 c1", dut.c1, 116);
        chk("v1 c2", dut.c2, 0);   chk("v1 c3", dut.c3, 8);
        chk("v1 c4", dut.c4, -15); chk("v1 c5", dut.c5, -9);
        chk("v1 c6", dut.c6, 41);  chk("v1 c7", dut.c7, 63);
        ex = '{260, 65, 6, 40, 14, 3, -3, -8};
        chk_out("v1");

        x_in = '{0, 0, 0, 0, 0, 0, 0, 0};
        #1;
        chk("zero a4", dut.a4, 0); chk("zero b0", dut.b0, 0);
        chk("zero b1", dut.b1, 0); chk("zero c7", dut.c7, 0);
        chk("zero d1", dut.d1, 0); chk("zero d6", dut.d6, 0);
        ex = '{0, 0, 0, 0, 0, 0, 0, 0};
        chk_out("zero");

        x_in = '{10, 10, 10, 10, 10, 10, 10, 10};
        #1;
        ex = '{80, 0, 0, 0, 0, 0, 0, 0};
        chk_out("ten");

        x_in = '{-128, -128, -128, -128, -128, -128, -128, -128};
        #1;
        ex = '{-1024, 0, 0, 0, 0, 0, 0, 0};
        chk_out("min");

        x_in = '{64, 0, 0, 0, 0, 0, 0, 0};
        #1;
        ex = '{64, 63, 55, 53, 32, 20, -24, 8};
        chk_out("imp");

        x_in = '{64, 32, 24, 28, 40, 34, 26, 12};
        ex = '{260, 65, 6, 40, 14, 3, -3, -8};
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(posedge clk);
            if (cyc == 2) srstn = 1'b1;
            if (cyc == 3) srstn = 1'b0;
            #1;
            chk_out($sformatf("hold%0d", cyc));
            @(negedge clk);
            chk_out($sformatf("holdn%0d", cyc));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fbin_dct.md
# fbin_dct

Combinational 8-point forward binDCT: a multiplierless, lifting-based integer approximation of the 1-D DCT-II. It takes one row of eight signed 8-bit samples and produces eight signed 32-bit coefficients in natural frequency order. It is the 1-D transform core of the image-coding datapath, and a transpose/2-D wrapper instantiates it.

## Interface
- Parameters: none. Widths and coefficients are fixed constants in the shared package.
- `clk`, input, 1 bit. Clock for interface uniformity; the datapath does not use it.
- `srstn`, input, 1 bit. Asynchronous, active-high reset. The port name follows codebase convention. The datapath does not use it.
- `x_in[0:7]`, input, unpacked array of 8 × signed 8-bit. Spatial samples x0..x7.
- `x_out[0:7]`, output, unpacked array of 8 × signed 32-bit. Coefficients X0..X7.

## Operation
- Each `x_in[i]` is sign-extended to 32 bits. All stages compute in 32-bit signed arithmetic.
- All `>>>` operations are arithmetic right shifts, i.e. floor division. There is no rounding and no saturation. Maximum |X| is 1024, so overflow cannot occur.
- Stage 1 (butterfly), named nets `a0..a7`:
  - a0=x0+x7, a1=x1+x6, a2=x2+x5, a3=x3+x4
  - a4=x3−x4, a5=x2−x5, a6=x1−x6, a7=x0−x7
- Stage 2 (π/4 lifting), named nets `b0, b1`:
  - b0 = a6 − ((13·a5)>>>5)
  - b1 = a5 + ((11·b0)>>>4)
- Stage 3, named nets `c0..c7`:
  - c0=a0+a3, c1=a1+a2, c2=a1−a2, c3=a0−a3
  - c4=a4+b1, c5=a4−b1, c6=a7−b0, c7=a7+b0
- Stage 4, named nets `d0..d6`:
  - d0 = c0+c1
  - d1 = (d0>>>1) − c1
  - d2 = c2 − ((3·c3)>>>3)
  - d3 = c3 + ((3·d2)>>>3)
  - d4 = c4 + (c7>>>3)
  - d5 = c5 + ((5·c6)>>>4)
  - d6 = c6 − ((9·d5)>>>4)
- Output mapping:
  - X0=d0, X1=c7−((3·d4)>>>4), X2=d3, X3=d6
  - X4=d1, X5=d5, X6=d2, X7=d4
- Constant multiplies are implemented as shift-add sums. No multiplier inference.
- Nets a*, b*, c*, d* keep exactly these names at module scope so benches can probe them hierarchically.

## Timing
- Fully combinational: `x_out` settles from `x_in` with zero cycles of latency.
- There is no internal state, so no reset value exists. `x_out` always reflects the current `x_in`, whatever the state of `clk` or `srstn`.
- Asserting or releasing `srstn`, at any time, has no effect on `x_out`.
- Toggling `clk` has no effect on `x_out`.
- No handshake: the consumer samples `x_out` in its own clock domain.

## Structure
- Package `fbindct_pkg`:
  - `IN_W`=8 and `OUT_W`=32
  - typedef `sample_t` (signed [7:0]) and `coef_t` (signed [31:0])
  - lifting constants as numerator/shift pairs: (13,5), (11,4), (3,3), (1,3), (5,4), (9,4), (3,4)
- Sub-module `bindct_lift`:
  - parameters K (numerator), S (shift), SUB (add/subtract)
  - computes y = a ± ((K·b)>>>S) using shift-add
  - the top instantiates it once per lifting step, 9 instances in total

## Test plan
- x = {64,32,24,28,40,34,26,12} -> intermediate and output values:
  - a = {76,58,58,68,−12,−10,6,52}
  - b0=11, b1=−3
  - c = {144,116,0,8,−15,−9,41,63}
  - x_out = {260,65,6,40,14,3,−3,−8}
- All zeros -> every intermediate and every output is 0.
- All x=10 -> x_out = {80,0,0,0,0,0,0,0}.
- All x=−128 -> x_out = {−1024,0,0,0,0,0,0,0}. This checks sign extension and the floor shift in d1.
- Impulse x0=64, others 0 -> x_out = {64,63,55,53,32,20,−24,8}. This checks negative floor shifts (d3 uses −72>>>3 = −9).
- Hold first vector, toggle `clk` for 5 cycles, pulse `srstn` high mid-run -> `x_out` stays {260,65,6,40,14,3,−3,−8} throughout.
